// File: rtl/fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl_if
// Purpose  : Handshake/status bundle between the FIFO pointer controller and
//            the logic around it (writer, reader, flow control).
// Ports    : none (interface signals only)
//   push_req, pop_req          requests from writer / reader
//   umbral_alto, umbral_bajo   almost-full / almost-empty thresholds
//   wr_ptr, rd_ptr             memory addresses
//   push, pop                  accepted write / read enables to the memory
//   count                      occupancy
//   full, empty                occupancy flags
//   almost_full, almost_empty  threshold flags
//   valid_out                  memory read data valid
//   error                      overflow / underflow indication
// Modports : master (requester side), slave (controller side)
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_ctrl_if #(
  parameter int PTR_L = 3
);
  logic             push_req;
  logic             pop_req;
  logic [PTR_L-1:0] umbral_alto;
  logic [PTR_L-1:0] umbral_bajo;
  logic [PTR_L-1:0] wr_ptr;
  logic [PTR_L-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [PTR_L-1:0] count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             valid_out;
  logic             error;

  modport master (
    output push_req, pop_req, umbral_alto, umbral_bajo,
    input  wr_ptr, rd_ptr, push, pop, count, full, empty,
           almost_full, almost_empty, valid_out, error
  );

  modport slave (
    input  push_req, pop_req, umbral_alto, umbral_bajo,
    output wr_ptr, rd_ptr, push, pop, count, full, empty,
           almost_full, almost_empty, valid_out, error
  );
endinterface : fifo_ctrl_if
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl
// Purpose  : Pointer, occupancy and status-flag controller for a FIFO memory.
//            Does not touch the data path.
// Ports    :
//   clk       in   single clock, rising edge
//   reset_L   in   asynchronous active-low reset
//   bus       slave modport of fifo_ctrl_if (requests, thresholds, pointers,
//             memory enables, occupancy and status flags)
// Params   : MEM_SIZE (entries, 2 .. 2^PTR_L-1), PTR_L (pointer/count width)
// Config   : FIFO_CTRL_ERROR_STICKY_EN - when defined, error holds until
//            reset; otherwise error is a one-cycle pulse per offending edge.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
  parameter int MEM_SIZE = 4,
  parameter int PTR_L    = 3
) (
  input  logic        clk,
  input  logic        reset_L,
  fifo_ctrl_if.slave  bus
);

  localparam logic [PTR_L-1:0] C_LAST_PTR = PTR_L'(MEM_SIZE - 1);
  localparam logic [PTR_L-1:0] C_FULL_CNT = PTR_L'(MEM_SIZE);
  localparam logic [PTR_L-1:0] C_ONE      = PTR_L'(1);

  logic [PTR_L-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_L-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_L-1:0] count_q,  count_d;
  logic             valid_q,  valid_d;
  logic             error_q,  error_d;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;
  logic w_overflow;
  logic w_underflow;

  // Flags come only from the registered count so they settle to their reset
  // values as soon as reset_L falls.
  assign w_full  = (count_q == C_FULL_CNT);
  assign w_empty = (count_q == '0);

  // A push into a full FIFO is fine when a pop frees a slot on the same edge.
  assign w_push_ok   = bus.push_req && (!w_full || bus.pop_req);
  assign w_pop_ok    = bus.pop_req && !w_empty;
  assign w_overflow  = bus.push_req && w_full && !bus.pop_req;
  assign w_underflow = bus.pop_req && w_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (w_push_ok) begin
      wr_ptr_d = (wr_ptr_q == C_LAST_PTR) ? '0 : wr_ptr_q + C_ONE;
    end
    if (w_pop_ok) begin
      rd_ptr_d = (rd_ptr_q == C_LAST_PTR) ? '0 : rd_ptr_q + C_ONE;
    end

    if (w_push_ok && !w_pop_ok) begin
      count_d = count_q + C_ONE;
    end else if (w_pop_ok && !w_push_ok) begin
      count_d = count_q - C_ONE;
    end

    // Memory registers the read word on the accepting edge; data is valid
    // for exactly the following cycle.
    valid_d = w_pop_ok;

`ifdef FIFO_CTRL_ERROR_STICKY_EN
    error_d = error_q || w_overflow || w_underflow;
`else
    error_d = w_overflow || w_underflow;
`endif
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign bus.wr_ptr       = wr_ptr_q;
  assign bus.rd_ptr       = rd_ptr_q;
  assign bus.push         = w_push_ok;
  assign bus.pop          = w_pop_ok;
  assign bus.count        = count_q;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  // Thresholds are live inputs; the flags track them within the cycle.
  assign bus.almost_full  = (count_q >= bus.umbral_alto);
  assign bus.almost_empty = (count_q <= bus.umbral_bajo);
  assign bus.valid_out    = valid_q;
  assign bus.error        = error_q;

endmodule : fifo_ctrl
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ctrl
// Purpose  : Directed self-checking bench for fifo_ctrl (MEM_SIZE=4, PTR_L=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

  localparam int MEM_SIZE = 4;
  localparam int PTR_L    = 3;
`ifdef FIFO_CTRL_ERROR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic clk;
  logic reset_L;
  int   n_total;
  int   n_bad;

  fifo_ctrl_if #(.PTR_L(PTR_L)) bus ();

  fifo_ctrl #(
    .MEM_SIZE (MEM_SIZE),
    .PTR_L    (PTR_L)
  ) u_dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset_L = 1'b0;
    bus.push_req    = 1'b0;
    bus.pop_req     = 1'b0;
    bus.umbral_alto = 3'd3;
    bus.umbral_bajo = 3'd1;

    tick();
    tick();
    reset_L = 1'b1;
    tick();

    // Idle after reset
    check("rst_count",  32'(bus.count), 0);
    check("rst_empty",  32'(bus.empty), 1);
    check("rst_aempty", 32'(bus.almost_empty), 1);
    check("rst_full",   32'(bus.full), 0);
    check("rst_afull",  32'(bus.almost_full), 0);
    check("rst_wrptr",  32'(bus.wr_ptr), 0);
    check("rst_rdptr",  32'(bus.rd_ptr), 0);
    check("rst_error",  32'(bus.error), 0);
    check("rst_valid",  32'(bus.valid_out), 0);

    // Fill: four pushes
    bus.push_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fill_push", 32'(bus.push), 1);
      tick();
      check("fill_wrptr", 32'(bus.wr_ptr), 32'((i + 1) % 4));
      check("fill_count", 32'(bus.count), 32'(i + 1));
      check("fill_empty", 32'(bus.empty), 0);
      check("fill_afull", 32'(bus.almost_full), (i + 1 >= 3) ? 1 : 0);
      check("fill_full",  32'(bus.full), (i == 3) ? 1 : 0);
    end

    // Fifth push while full: overflow
    #1;
    check("ovf_push", 32'(bus.push), 0);
    tick();
    check("ovf_wrptr", 32'(bus.wr_ptr), 0);
    check("ovf_count", 32'(bus.count), 4);
    check("ovf_error", 32'(bus.error), 1);
    bus.push_req = 1'b0;
    tick();
    check("ovf_error_next", 32'(bus.error), 32'(STICKY));

    // Drain: four pops
    bus.pop_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_pop", 32'(bus.pop), 1);
      tick();
      check("drain_rdptr",  32'(bus.rd_ptr), 32'((i + 1) % 4));
      check("drain_count",  32'(bus.count), 32'(3 - i));
      check("drain_valid",  32'(bus.valid_out), 1);
      check("drain_aempty", 32'(bus.almost_empty), ((3 - i) <= 1) ? 1 : 0);
      check("drain_empty",  32'(bus.empty), (i == 3) ? 1 : 0);
    end

    // Pop on empty together with a push: push only, underflow
    bus.push_req = 1'b1;
    #1;
    check("unf_pop",  32'(bus.pop), 0);
    check("unf_push", 32'(bus.push), 1);
    tick();
    check("unf_count", 32'(bus.count), 1);
    check("unf_error", 32'(bus.error), 1);
    check("unf_valid", 32'(bus.valid_out), 0);
    check("unf_wrptr", 32'(bus.wr_ptr), 1);
    check("unf_rdptr", 32'(bus.rd_ptr), 0);

    // Refill to full
    bus.pop_req = 1'b0;
    tick();
    tick();
    tick();
    check("refill_count", 32'(bus.count), 4);
    check("refill_full",  32'(bus.full), 1);
    check("refill_wrptr", 32'(bus.wr_ptr), 0);
    check("refill_error", 32'(bus.error), 32'(STICKY));

    // Simultaneous push+pop while full
    bus.pop_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("both_push", 32'(bus.push), 1);
      check("both_pop",  32'(bus.pop), 1);
      tick();
      check("both_count", 32'(bus.count), 4);
      check("both_valid", 32'(bus.valid_out), 1);
    end
    check("both_wrptr", 32'(bus.wr_ptr), 3);
    check("both_rdptr", 32'(bus.rd_ptr), 3);
    check("both_error", 32'(bus.error), 32'(STICKY));

    // Asynchronous reset mid-burst, checked before the next edge
    #2;
    reset_L = 1'b0;
    #1;
    check("arst_count",  32'(bus.count), 0);
    check("arst_wrptr",  32'(bus.wr_ptr), 0);
    check("arst_rdptr",  32'(bus.rd_ptr), 0);
    check("arst_valid",  32'(bus.valid_out), 0);
    check("arst_error",  32'(bus.error), 0);
    check("arst_empty",  32'(bus.empty), 1);
    check("arst_full",   32'(bus.full), 0);
    check("arst_aempty", 32'(bus.almost_empty), 1);
    check("arst_afull",  32'(bus.almost_full), 0);
    check("arst_push",   32'(bus.push), 1);
    check("arst_pop",    32'(bus.pop), 0);

    // Thresholds act combinationally
    bus.umbral_alto = 3'd0;
    #1;
    check("thr_afull_zero", 32'(bus.almost_full), 1);
    bus.umbral_bajo = 3'd0;
    #1;
    check("thr_aempty_zero", 32'(bus.almost_empty), 1);

    bus.push_req = 1'b0;
    bus.pop_req  = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Absolute time bound so the bench always ends.
  initial begin
    #20000;
    n_bad++;
    $display("FAIL timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_fifo_ctrl
`default_nettype wire
